// File: rtl/en_gate_pkg.sv
// Shared types and helpers for the packet-aligned enable gate.
package en_gate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } gate_state_t;

    // Increment a w-bit counter (carried in 64 bits), holding at all-ones.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/en_sync2.sv
// Two-flop level synchronizer for the software enable, reset low.
module en_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/en_capture_gate.sv
// Packet-aligned gate: opens only on SOP, closes only after EOP, drops
// words while closed without back-pressure, and counts packets/drops.
module en_capture_gate
    import en_gate_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    output logic              running,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  drop_count
);

    gate_state_t state;
    logic        en_s;
    logic        fwd_state;
    logic        fwd;
    logic        acc;
    logic        load;

    en_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (en_in),
        .q     (en_s)
    );

    assign fwd_state = (state == RUN) || (state == STOP);
    assign fwd       = fwd_state || ((state == ARMED) && in_sop);

    // ARMED never stalls plain drops, but an opening SOP must not overwrite a
    // previous packet's last word still stalled in the output stage.
    always_comb begin
        in_ready = 1'b1;
        if (fwd_state || ((state == ARMED) && in_valid && in_sop))
            in_ready = ~out_valid | out_ready;
    end

    assign acc  = in_valid & in_ready;
    assign load = acc & fwd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en_s) state <= ARMED;
                ARMED: begin
                    if (acc && in_sop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (!en_s) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (!en_s) begin
                        if (acc && in_eop) begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end else begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (acc && in_eop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (en_s) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sop   <= in_sop;
            out_eop   <= in_eop;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (load && in_eop)
                pkt_count <= CNT_W'(sat_inc(64'(pkt_count), CNT_W));
            if (acc && !fwd)
                drop_count <= CNT_W'(sat_inc(64'(drop_count), CNT_W));
        end
    end

endmodule

// File: tb/tb_en_capture_gate.sv
// Directed bench for en_capture_gate: drops, packet alignment, back-pressure,
// single-beat packets, counter saturation and asynchronous reset.
module tb_en_capture_gate;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_in;
    logic [31:0] in_data;
    logic        in_valid, in_sop, in_eop, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_sop, out_eop, out_ready;
    logic        running;
    logic [31:0] pkt_count, drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    en_capture_gate #(.DATA_W(32), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .en_in      (en_in),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready),
        .running    (running),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int          idx, rx_n;
        logic        stall_prev;
        logic [31:0] held;

        reset = 1'b1; en_in = 1'b0; in_data = '0; in_valid = 1'b0;
        in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_running", running, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_data", out_data, 0);
        step();
        reset = 1'b0;

        // Disabled: ten words dropped, never stalled.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 32'(i); in_sop = (i == 0); in_eop = (i == 9);
            #1;
            chk("off_in_ready", in_ready, 1);
            step();
            chk("off_out_valid", out_valid, 0);
        end
        idle(1);
        chk("off_drop", drop_count, 10);

        // Enable mid-packet: first packet dropped, second forwarded.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) en_in = 1'b1;
            beat(32'hA00 + 32'(i), i == 0, i == 15);
            chk("armA_out_valid", out_valid, 0);
        end
        for (int i = 0; i < 16; i++) begin
            beat(32'hB00 + 32'(i), i == 0, i == 15);
            chk("pktB_valid", out_valid, 1);
            chk("pktB_data", out_data, 32'hB00 + 32'(i));
            chk("pktB_sop", out_sop, i == 0);
            chk("pktB_eop", out_eop, i == 15);
        end
        idle(1);
        chk("pktB_count", pkt_count, 1);
        chk("pktB_drop", drop_count, 16);

        // Disable at word 5: packet still completes, next one dropped.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) en_in = 1'b0;
            beat(32'hC00 + 32'(i), i == 0, i == 15);
            chk("pktC_data", out_data, 32'hC00 + 32'(i));
            chk("pktC_valid", out_valid, 1);
            if (i == 10) chk("pktC_running_stop", running, 1);
        end
        chk("pktC_idle", running, 0);
        for (int i = 0; i < 16; i++) begin
            beat(32'hD00 + 32'(i), i == 0, i == 15);
            chk("pktD_out_valid", out_valid, 0);
        end
        idle(1);
        chk("pktD_pkt", pkt_count, 2);
        chk("pktD_drop", drop_count, 32);

        // Back-pressure with out_ready toggling 1010...
        do_reset();
        en_in = 1'b1;
        idle(4);
        idx = 0; rx_n = 0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && rx_n < 16; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (idx < 16);
            in_data   = 32'(idx);
            in_sop    = (idx == 0);
            in_eop    = (idx == 15);
            #1;
            if (stall_prev) chk("bp_hold", out_data, held);
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, 64'(rx_n));
                chk("bp_sop", out_sop, rx_n == 0);
                chk("bp_eop", out_eop, rx_n == 15);
                rx_n++;
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            if (in_valid && in_ready) idx++;
            step();
        end
        out_ready = 1'b1;
        idle(1);
        chk("bp_rx_count", 64'(rx_n), 16);
        chk("bp_pkt", pkt_count, 1);
        chk("bp_drop", drop_count, 0);

        // Single-beat packets back to back.
        do_reset();
        en_in = 1'b1;
        idle(4);
        for (int i = 0; i < 8; i++) begin
            beat(32'h50 + 32'(i), 1'b1, 1'b1);
            chk("sb_data", out_data, 32'h50 + 32'(i));
            chk("sb_sop_eop", {out_valid, out_sop, out_eop}, 3'b111);
        end
        chk("sb_pkt8", pkt_count, 8);
        // en_s falls on the third edge, together with an EOP in RUN.
        en_in = 1'b0;
        beat(32'h60, 1'b1, 1'b1);
        beat(32'h61, 1'b1, 1'b1);
        chk("sb_still_run", running, 1);
        beat(32'h62, 1'b1, 1'b1);
        chk("sb_eop_idle", running, 0);
        chk("sb_pkt11", pkt_count, 11);
        beat(32'h63, 1'b1, 1'b1);
        idle(1);
        chk("sb_after_drop", drop_count, 1);

        // Saturation of the drop counter.
        do_reset();
        force dut.drop_count = 32'hFFFF_FFFE;
        #1;
        release dut.drop_count;
        beat(32'h1, 1'b0, 1'b0);
        chk("sat_drop1", drop_count, 32'hFFFF_FFFF);
        beat(32'h2, 1'b0, 1'b0);
        beat(32'h3, 1'b0, 1'b0);
        chk("sat_drop3", drop_count, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a forwarded packet.
        en_in = 1'b1;
        idle(4);
        beat(32'hE0, 1'b1, 1'b0);
        beat(32'hE1, 1'b0, 1'b0);
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_running", running, 1);
        reset = 1'b1;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_sop_eop", {out_sop, out_eop}, 2'b00);
        chk("mid_out_data", out_data, 0);
        chk("mid_running", running, 0);
        chk("mid_counts", {pkt_count, drop_count}, 64'h0);
        chk("mid_in_ready", in_ready, 1);
        step();
        reset = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
